// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
//
// Two-stage pipelined RISC-V immediate encoder. Scatters a 32-bit immediate
// into the I/S/B/J/U instruction bit positions and merges it into a base
// instruction word. The format select uses the same encoding as the core's
// immediate extender, so an encode/extend pair round-trips.
//
//   Stage 1 (check): registers the request and classifies the immediate.
//   Stage 2 (pack) : builds the instruction word and presents the result.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset_n    in   1   asynchronous active-low reset
//   in_valid   in   1   request valid
//   in_ready   out  1   request can be accepted this cycle (combinational
//                       on out_ready)
//   in_immsrc  in   3   000 I, 001 S, 010 B, 011 J, 100 U, others unsupported
//   in_imm     in  32   immediate, two's complement (byte offset for B/J)
//   in_base    in  32   instruction word; immediate-field bits are replaced
//   out_valid  out  1   result valid
//   out_ready  in   1   consumer accepts the result
//   out_instr  out 32   encoded instruction
//   out_err    out  2   00 ok, 01 out of range, 10 misaligned, 11 unsupported
//   err_cnt    out  8   saturating count of delivered errored results
//
// Build option:
//   IMM_ENCODER_ERR_CNT_EN  when defined, the saturating error counter is
//                           built; otherwise err_cnt is tied to zero.
// -----------------------------------------------------------------------------
module imm_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_immsrc,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [1:0]  out_err,
  output logic [7:0]  err_cnt
);

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_J = 3'b011;
  localparam logic [2:0] FMT_U = 3'b100;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_FMT   = 2'b11;

  // Classify an immediate for the selected format. Unsupported format wins
  // over misalignment, which wins over range.
  function automatic logic [1:0] f_check_err(input logic [2:0]  immsrc,
                                             input logic [31:0] imm);
    logic [1:0] err;
    err = ERR_OK;
    case (immsrc)
      FMT_I, FMT_S: begin
        // 12-bit signed field: bits above bit 10 must all be sign copies
        if (!((&imm[31:11]) || !(|imm[31:11]))) err = ERR_RANGE;
        else                                    err = ERR_OK;
      end
      FMT_B: begin
        if (imm[0])                                  err = ERR_ALIGN;
        else if (!((&imm[31:12]) || !(|imm[31:12]))) err = ERR_RANGE;
        else                                         err = ERR_OK;
      end
      FMT_J: begin
        if (imm[0])                                  err = ERR_ALIGN;
        else if (!((&imm[31:20]) || !(|imm[31:20]))) err = ERR_RANGE;
        else                                         err = ERR_OK;
      end
      FMT_U: begin
        // U carries only the upper 20 bits; any low bit is lost
        if (|imm[11:0]) err = ERR_RANGE;
        else            err = ERR_OK;
      end
      default: err = ERR_FMT;
    endcase
    return err;
  endfunction

  // Scatter the immediate into its instruction fields over the base word.
  // Out-of-range or misaligned immediates are still packed from the
  // truncated bits so the output is deterministic.
  function automatic logic [31:0] f_pack(input logic [2:0]  immsrc,
                                         input logic [31:0] imm,
                                         input logic [31:0] base);
    logic [31:0] word;
    word = base;
    case (immsrc)
      FMT_I: word[31:20] = imm[11:0];
      FMT_S: begin
        word[31:25] = imm[11:5];
        word[11:7]  = imm[4:0];
      end
      FMT_B: begin
        word[31]    = imm[12];
        word[30:25] = imm[10:5];
        word[11:8]  = imm[4:1];
        word[7]     = imm[11];
      end
      FMT_J: begin
        word[31]    = imm[20];
        word[30:21] = imm[10:1];
        word[20]    = imm[11];
        word[19:12] = imm[19:12];
      end
      FMT_U:   word[31:12] = imm[31:12];
      default: word = base;
    endcase
    return word;
  endfunction

  // Stage 1 holding registers
  logic        r_s1_valid;
  logic [2:0]  r_s1_immsrc;
  logic [31:0] r_s1_imm;
  logic [31:0] r_s1_base;
  logic [1:0]  r_s1_err;

  // Stage 2 (output) registers
  logic        r_s2_valid;
  logic [31:0] r_s2_instr;
  logic [1:0]  r_s2_err;

  logic        w_s2_free;
  logic        w_s2_load;
  logic        w_in_fire;
  logic [1:0]  w_in_err;
  logic [31:0] w_s1_packed;

  // Stage 2 can take a new entry when empty or when it is draining now;
  // this is what lets a drain and an accept happen in the same cycle.
  assign w_s2_free   = !r_s2_valid || out_ready;
  assign w_s2_load   = r_s1_valid && w_s2_free;
  assign in_ready    = !r_s1_valid || w_s2_load;
  assign w_in_fire   = in_valid && in_ready;
  assign w_in_err    = f_check_err(in_immsrc, in_imm);
  assign w_s1_packed = f_pack(r_s1_immsrc, r_s1_imm, r_s1_base);

  // Two-entry pipeline: check stage and pack stage with valid/ready advance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_immsrc <= 3'b000;
      r_s1_imm    <= 32'h0000_0000;
      r_s1_base   <= 32'h0000_0000;
      r_s1_err    <= 2'b00;
      r_s2_valid  <= 1'b0;
      r_s2_instr  <= 32'h0000_0000;
      r_s2_err    <= 2'b00;
    end else begin
      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_s2_instr <= w_s1_packed;
        r_s2_err   <= r_s1_err;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end else begin
        // stalled: hold the presented result stable
        r_s2_valid <= r_s2_valid;
      end

      if (w_in_fire) begin
        r_s1_valid  <= 1'b1;
        r_s1_immsrc <= in_immsrc;
        r_s1_imm    <= in_imm;
        r_s1_base   <= in_base;
        r_s1_err    <= w_in_err;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end else begin
        r_s1_valid <= r_s1_valid;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_instr = r_s2_instr;
  assign out_err   = r_s2_err;

`ifdef IMM_ENCODER_ERR_CNT_EN
  logic [7:0] r_err_cnt;
  logic       w_out_fire;

  assign w_out_fire = r_s2_valid && out_ready;

  // Saturating count of errored results taken by the consumer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_out_fire && (r_s2_err != ERR_OK) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end else begin
      r_err_cnt <= r_err_cnt;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// -----------------------------------------------------------------------------
// tb_imm_encoder
//
// Directed, table-driven bench for imm_encoder. Each table record carries the
// request and the hand-computed instruction and status. Backpressure,
// counter saturation and mid-flight reset are exercised by short hand-written
// sequences. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_imm_encoder;

`ifdef IMM_ENCODER_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_immsrc;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [1:0]  out_err;
  logic [7:0]  err_cnt;

  imm_encoder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_immsrc (in_immsrc),
    .in_imm    (in_imm),
    .in_base   (in_base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  immsrc;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] exp_instr;
    logic [1:0]  exp_err;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_pass   = 0;
  int cnt_model = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic model_count(input logic [1:0] err);
    if (CNT_EN && (err != 2'b00) && (cnt_model < 255)) cnt_model++;
  endtask

  task automatic drive(input int i);
    in_immsrc = vecs[i].immsrc;
    in_imm    = vecs[i].imm;
    in_base   = vecs[i].base;
  endtask

  // Called at a falling edge with an empty pipe and out_ready high.
  task automatic apply_vec(input int i);
    drive(i);
    in_valid = 1'b1;
    chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk($sformatf("vec%0d_not_yet_valid", i), {31'd0, out_valid}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
    chk($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp_instr);
    chk($sformatf("vec%0d_err", i), {30'd0, out_err}, {30'd0, vecs[i].exp_err});
    model_count(vecs[i].exp_err);
    @(posedge clk); @(negedge clk);
    chk($sformatf("vec%0d_drained", i), {31'd0, out_valid}, 32'd0);
    chk($sformatf("vec%0d_err_cnt", i), {24'd0, err_cnt}, cnt_model);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          immsrc  imm            base           instr          err
    vecs[0]  = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0093, 32'hFFF0_0093, 2'b00};
    vecs[1]  = '{3'b010, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 2'b00};
    vecs[2]  = '{3'b011, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 2'b00};
    vecs[3]  = '{3'b100, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 2'b00};
    vecs[4]  = '{3'b001, 32'hFFFF_FFF8, 32'h0000_2023, 32'hFE00_2C23, 2'b00};
    vecs[5]  = '{3'b000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h000F_FFFF, 2'b00};
    vecs[6]  = '{3'b000, 32'h0000_0800, 32'h0000_0093, 32'h8000_0093, 2'b01};
    vecs[7]  = '{3'b010, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 2'b10};
    vecs[8]  = '{3'b101, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 2'b11};
    vecs[9]  = '{3'b100, 32'h1234_5001, 32'h0000_0037, 32'h1234_5037, 2'b01};
    vecs[10] = '{3'b011, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 2'b01};
    vecs[11] = '{3'b011, 32'h0000_0001, 32'h0000_006F, 32'h0000_006F, 2'b10};
    vecs[12] = '{3'b111, 32'h0000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b11};
    vecs[13] = '{3'b001, 32'h0000_0800, 32'h0000_0023, 32'h8000_0023, 2'b01};
    vecs[14] = '{3'b011, 32'hFFF0_0000, 32'h0000_006F, 32'h8000_006F, 2'b00};
    vecs[15] = '{3'b010, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 2'b00};
    vecs[16] = '{3'b010, 32'h0000_1000, 32'h0000_0063, 32'h8000_0063, 2'b01};
    vecs[17] = '{3'b000, 32'hFFFF_F800, 32'h0000_0093, 32'h8000_0093, 2'b00};
    vecs[18] = '{3'b100, 32'h0000_0800, 32'h0000_0037, 32'h0000_0037, 2'b01};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_immsrc = 3'b000;
    in_imm    = 32'h0;
    in_base   = 32'h0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", {30'd0, out_err}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Table of single transactions
    for (int i = 0; i < NVEC; i++) apply_vec(i);

    // Backpressure: three back-to-back offers with the consumer stalled
    out_ready = 1'b0;
    drive(0); in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("bp_ready_after_1", {31'd0, in_ready}, 32'd1);
    drive(1);
    @(posedge clk); @(negedge clk);
    chk("bp_ready_after_2", {31'd0, in_ready}, 32'd0);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_instr_a", out_instr, vecs[0].exp_instr);
    drive(2);
    @(posedge clk); @(negedge clk);
    chk("bp_still_full", {31'd0, in_ready}, 32'd0);
    chk("bp_stable_instr", out_instr, vecs[0].exp_instr);
    chk("bp_stable_err", {30'd0, out_err}, {30'd0, vecs[0].exp_err});
    chk("bp_stable_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", {31'd0, in_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("bp_out_b_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_out_b", out_instr, vecs[1].exp_instr);
    @(posedge clk); @(negedge clk);
    chk("bp_out_c_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_out_c", out_instr, vecs[2].exp_instr);
    @(posedge clk); @(negedge clk);
    chk("bp_empty", {31'd0, out_valid}, 32'd0);
    chk("bp_err_cnt", {24'd0, err_cnt}, cnt_model);

    // Saturation: 260 errored results streamed at full rate
    drive(8); in_valid = 1'b1;
    for (int k = 0; k < 260; k++) begin
      @(posedge clk);
      model_count(2'b11);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat_err_cnt", {24'd0, err_cnt}, cnt_model);
    chk("sat_empty", {31'd0, out_valid}, 32'd0);

    // Reset with two requests in flight
    out_ready = 1'b0;
    drive(6); in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    drive(7);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    reset_n = 1'b0;
    cnt_model = 0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    chk("mid_rst_instr", out_instr, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("post_rst_no_stale%0d", k), {31'd0, out_valid}, 32'd0);
    end
    apply_vec(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
